// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC shot controller and its echo accumulator.
package tdc_pkg;

  // Width of tof/range words and of beat intensity, fixed by the TDC output format.
  localparam int RANGE_W = 15;
  localparam int INT_W   = 4;

  // A tof of all ones marks a beat with no echo inside the programmed range.
  localparam logic [RANGE_W-1:0] TOF_INVALID = {RANGE_W{1'b1}};

  // Frame sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_COLLECT = 3'd4,
    ST_GAP     = 3'd5,
    ST_REPORT  = 3'd6
  } state_t;

endpackage

// File: rtl/tdc_echo_accum.sv
// Beat-level reducer: tracks the nearest valid echo of a frame, its intensity,
// the number of valid echoes (saturating) and the number of shots with a hit.
module tdc_echo_accum
  import tdc_pkg::*;
#(
  parameter int SHOT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_beat,
  input  logic               i_shot_end,
  input  logic [RANGE_W-1:0] i_tof,
  input  logic [INT_W-1:0]   i_int,
  input  logic [1:0]         i_num,
  output logic [RANGE_W-1:0] o_min_tof,
  output logic [INT_W-1:0]   o_min_int,
  output logic [SHOT_W-1:0]  o_hits,
  output logic [SHOT_W+1:0]  o_echoes
);

  localparam logic [SHOT_W+1:0] ECHO_MAX = '1;
  localparam logic [SHOT_W+1:0] ECHO_ONE = (SHOT_W+2)'(1);

  logic [RANGE_W-1:0] r_min_tof;
  logic [INT_W-1:0]   r_min_int;
  logic [SHOT_W-1:0]  r_hits;
  logic [SHOT_W+1:0]  r_echoes;
  logic               r_shot_hit;

  logic w_echo;
  logic w_shot_hit;

  // An echo is a consumed beat of a non-empty shot whose tof lies inside the range.
  assign w_echo     = i_beat && (i_num != 2'd0) && (i_tof != TOF_INVALID);
  assign w_shot_hit = r_shot_hit | w_echo;

  // Accumulate echoes and per-shot hit flag; strict compare keeps the earliest of equal tofs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_min_tof  <= TOF_INVALID;
      r_min_int  <= '0;
      r_hits     <= '0;
      r_echoes   <= '0;
      r_shot_hit <= 1'b0;
    end else if (i_clear) begin
      r_min_tof  <= TOF_INVALID;
      r_min_int  <= '0;
      r_hits     <= '0;
      r_echoes   <= '0;
      r_shot_hit <= 1'b0;
    end else begin
      if (w_echo) begin
        if (r_echoes != ECHO_MAX) begin
          r_echoes <= r_echoes + ECHO_ONE;
        end
        if (i_tof < r_min_tof) begin
          r_min_tof <= i_tof;
          r_min_int <= i_int;
        end
      end
      if (i_beat && i_shot_end) begin
        r_hits     <= r_hits + SHOT_W'(w_shot_hit);
        r_shot_hit <= 1'b0;
      end else begin
        r_shot_hit <= w_shot_hit;
      end
    end
  end

  assign o_min_tof = r_min_tof;
  assign o_min_int = r_min_int;
  assign o_hits    = r_hits;
  assign o_echoes  = r_echoes;

endmodule

// File: rtl/tdc_shot_ctrl.sv
// Frame sequencer for the TDC: runs cfg_shots measurement shots (range setup,
// start pulse, wait for result stream, drain it, idle gap) and presents one
// summary record per frame on a ready/valid port.
module tdc_shot_ctrl
  import tdc_pkg::*;
#(
  parameter int SHOT_W    = 8,
  parameter int START_LEN = 2,
  parameter int TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_req,
  input  logic               frame_abort,
  input  logic [SHOT_W-1:0]  cfg_shots,
  input  logic [RANGE_W-1:0] cfg_range,
  input  logic [7:0]         cfg_gap,
  output logic               tdc_start,
  output logic [RANGE_W-1:0] tdc_range,
  input  logic               tdc_int,
  input  logic [RANGE_W-1:0] tdc_odata,
  input  logic [INT_W-1:0]   tdc_oint,
  input  logic [1:0]         tdc_onum,
  input  logic               tdc_olast,
  input  logic               tdc_ovalid,
  output logic               tdc_oready,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [RANGE_W-1:0] res_tof,
  output logic [INT_W-1:0]   res_int,
  output logic [SHOT_W-1:0]  res_hits,
  output logic [SHOT_W+1:0]  res_echoes,
  output logic [SHOT_W-1:0]  res_timeouts,
  output logic               busy
);

  // One shared down-the-road counter serves the start pulse, the timeout and the gap.
  localparam int               CNT_W        = 16;
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_LEN - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [SHOT_W-1:0] SHOT_ONE    = SHOT_W'(1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [SHOT_W-1:0]   r_cfg_shots;
  logic [7:0]          r_cfg_gap;
  logic [RANGE_W-1:0]  r_range;
  logic [SHOT_W-1:0]   r_shots_done;
  logic [SHOT_W-1:0]   r_timeouts;
  logic                r_tdc_start;
  logic                r_oready;
  logic                r_res_valid;
  logic [RANGE_W-1:0]  r_res_tof;
  logic [INT_W-1:0]    r_res_int;
  logic [SHOT_W-1:0]   r_res_hits;
  logic [SHOT_W+1:0]   r_res_echoes;
  logic [SHOT_W-1:0]   r_res_timeouts;

  logic                w_abort;
  logic                w_acc_clear;
  logic                w_beat;
  logic                w_shot_end;
  logic                w_last_shot;
  logic [CNT_W-1:0]    w_gap_last;
  logic [RANGE_W-1:0]  w_min_tof;
  logic [INT_W-1:0]    w_min_int;
  logic [SHOT_W-1:0]   w_hits;
  logic [SHOT_W+1:0]   w_echoes;
  logic                w_unused_int;

  // The result interrupt is only advisory; sequencing follows the beat stream.
  assign w_unused_int = tdc_int;

  // Abort is honoured everywhere a frame is running, except once the result is on offer.
  assign w_abort     = frame_abort && (r_state != ST_IDLE) && (r_state != ST_REPORT);
  assign w_acc_clear = (r_state == ST_IDLE) && frame_req;
  // oready is high only in WAIT/COLLECT, and the TDC never stalls, so valid means consumed.
  assign w_beat      = r_oready && tdc_ovalid && !w_abort;
  assign w_shot_end  = w_beat && (tdc_olast || (tdc_onum == 2'd0));
  assign w_last_shot = ((r_shots_done + SHOT_ONE) == r_cfg_shots);
  // A programmed gap of zero still idles one cycle so the TDC can clear itself.
  assign w_gap_last  = (r_cfg_gap == 8'd0) ? '0 : {8'd0, r_cfg_gap - 8'd1};

  tdc_echo_accum #(
    .SHOT_W(SHOT_W)
  ) u_accum (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_acc_clear),
    .i_beat    (w_beat),
    .i_shot_end(w_shot_end),
    .i_tof     (tdc_odata),
    .i_int     (tdc_oint),
    .i_num     (tdc_onum),
    .o_min_tof (w_min_tof),
    .o_min_int (w_min_int),
    .o_hits    (w_hits),
    .o_echoes  (w_echoes)
  );

  // Frame sequencer with registered TDC handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_cfg_shots    <= '0;
      r_cfg_gap      <= '0;
      r_range        <= '0;
      r_shots_done   <= '0;
      r_timeouts     <= '0;
      r_tdc_start    <= 1'b0;
      r_oready       <= 1'b0;
      r_res_valid    <= 1'b0;
      r_res_tof      <= TOF_INVALID;
      r_res_int      <= '0;
      r_res_hits     <= '0;
      r_res_echoes   <= '0;
      r_res_timeouts <= '0;
    end else if (w_abort) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_tdc_start <= 1'b0;
      r_oready    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (frame_req) begin
            r_cfg_shots  <= cfg_shots;
            r_cfg_gap    <= cfg_gap;
            r_range      <= cfg_range;
            r_shots_done <= '0;
            r_timeouts   <= '0;
            r_cnt        <= '0;
            if (cfg_shots == '0) begin
              // Empty frame: report straight away with a cleared record.
              r_state        <= ST_REPORT;
              r_res_valid    <= 1'b1;
              r_res_tof      <= TOF_INVALID;
              r_res_int      <= '0;
              r_res_hits     <= '0;
              r_res_echoes   <= '0;
              r_res_timeouts <= '0;
            end else begin
              r_state <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          // Range has been on the pins for at least this cycle before start rises.
          r_state     <= ST_START;
          r_tdc_start <= 1'b1;
          r_cnt       <= '0;
        end
        ST_START: begin
          if (r_cnt == START_LAST) begin
            r_state     <= ST_WAIT;
            r_tdc_start <= 1'b0;
            r_oready    <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_WAIT: begin
          if (tdc_ovalid) begin
            // A single-beat shot needs no COLLECT cycle.
            if (w_shot_end) begin
              r_state  <= ST_GAP;
              r_oready <= 1'b0;
              r_cnt    <= '0;
            end else begin
              r_state <= ST_COLLECT;
            end
          end else if (r_cnt == TIMEOUT_LAST) begin
            r_state    <= ST_GAP;
            r_oready   <= 1'b0;
            r_cnt      <= '0;
            r_timeouts <= r_timeouts + SHOT_ONE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_COLLECT: begin
          if (w_shot_end) begin
            r_state  <= ST_GAP;
            r_oready <= 1'b0;
            r_cnt    <= '0;
          end
        end
        ST_GAP: begin
          if (r_cnt == w_gap_last) begin
            r_cnt        <= '0;
            r_shots_done <= r_shots_done + SHOT_ONE;
            if (w_last_shot) begin
              r_state        <= ST_REPORT;
              r_res_valid    <= 1'b1;
              r_res_tof      <= w_min_tof;
              r_res_int      <= w_min_int;
              r_res_hits     <= w_hits;
              r_res_echoes   <= w_echoes;
              r_res_timeouts <= r_timeouts;
            end else begin
              r_state <= ST_SETUP;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_REPORT: begin
          if (res_ready) begin
            r_state     <= ST_IDLE;
            r_res_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_tdc_start <= 1'b0;
          r_oready    <= 1'b0;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign tdc_start    = r_tdc_start;
  assign tdc_range    = r_range;
  assign tdc_oready   = r_oready;
  assign res_valid    = r_res_valid;
  assign res_tof      = r_res_tof;
  assign res_int      = r_res_int;
  assign res_hits     = r_res_hits;
  assign res_echoes   = r_res_echoes;
  assign res_timeouts = r_res_timeouts;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: doc/tdc_shot_ctrl.md
Name: tdc_shot_ctrl

Overview:
- Sequences repeated measurement shots on the TDC datapath for one frame.
- Per shot: programs range, pulses the TDC start, waits for the TDC result interrupt, and drains the TDC output stream (tof/intensity beats).
- Reduces all shots of a frame to one summary record (nearest echo, its intensity, hit/echo/timeout counts) on a ready/valid result port for the core logic.

Parameters:
- SHOT_W, 8, width of shot count and hit counter
- RANGE_W, 15, tof/range width (matches TDC data)
- START_LEN, 2, tdc_start high time in clk cycles
- TIMEOUT, 1024, max clk cycles from start falling edge to first beat

Ports:
- clk  in  1  250 MHz logic clock
- rst  in  1  asynchronous reset, active-high
- frame_req  in  1  pulse; starts a frame when idle
- frame_abort  in  1  level/pulse; aborts the frame, no report
- cfg_shots  in  SHOT_W  shots per frame, sampled at frame_req
- cfg_range  in  RANGE_W  range, sampled at frame_req
- cfg_gap  in  8  idle cycles after each shot, sampled at frame_req
- tdc_start  out  1  start pulse to TDC
- tdc_range  out  RANGE_W  range to TDC, stable for the whole frame
- tdc_int  in  1  TDC result-ready interrupt
- tdc_odata  in  RANGE_W  beat tof; all-ones = out of range
- tdc_oint  in  4  beat intensity
- tdc_onum  in  2  echoes in this shot (0..3)
- tdc_olast  in  1  last beat
- tdc_ovalid  in  1  beat valid
- tdc_oready  out  1  ready to TDC
- res_valid  out  1  summary valid
- res_ready  in  1  summary accepted
- res_tof  out  RANGE_W  minimum valid tof in frame; all-ones if none
- res_int  out  4  intensity of the res_tof beat
- res_hits  out  SHOT_W  shots with at least one valid echo
- res_echoes  out  SHOT_W+2  total valid echoes, saturating
- res_timeouts  out  SHOT_W  shots that timed out
- busy  out  1  frame in progress (not IDLE)

Behaviour:
- Reset values: all outputs 0, except res_tof = all-ones. FSM in IDLE.
- IDLE:
  - On frame_req, latch cfg_*, clear accumulators, go to SETUP.
  - frame_req outside IDLE is ignored.
- SETUP (1 cycle):
  - tdc_range already driven; go to START.
  - Guarantees range is stable at least 1 cycle before the start edge.
- START:
  - tdc_start = 1 for exactly START_LEN cycles, then WAIT.
  - Timeout counter clears on entry to WAIT.
- WAIT:
  - tdc_oready = 1.
  - First tdc_ovalid goes to COLLECT and that beat is processed in the same cycle.
  - tdc_int is informational only; the FSM is driven by ovalid.
  - Counter reaches TIMEOUT-1 with no beat: res_timeouts++, go to GAP.
- COLLECT:
  - tdc_oready = 1.
  - The TDC cannot stall mid-packet, so every cycle with ovalid is a consumed beat.
  - Beat with tdc_onum==0 is an empty shot: ends the shot, no echo counted.
  - Otherwise, if odata != all-ones: echoes++ (saturating), shot_hit = 1.
  - If additionally odata < cur_min (strict, so ties keep the earlier beat), update cur_min and cur_int.
  - Shot ends on olast or on the onum==0 beat. At shot end, hits += shot_hit, then GAP.
  - Consecutive-cycle beats must be handled back to back.
- GAP:
  - tdc_oready = 0, idle for cfg_gap cycles; the TDC clears its internal state here.
  - cfg_gap = 0 means 1 cycle.
  - Then shots_done++. If shots_done == cfg_shots go to REPORT, else SETUP.
- REPORT:
  - res_* registered from the accumulators; res_valid = 1 and held stable until res_ready.
  - On res_valid && res_ready: res_valid = 0, go to IDLE.
- cfg_shots == 0: SETUP is skipped; go directly to REPORT with zero counts and res_tof all-ones.
- frame_abort:
  - In any non-IDLE state other than REPORT: next cycle IDLE, tdc_start = 0, tdc_oready = 0, no report.
  - In REPORT: ignored.
  - Beats arriving in IDLE are not accepted (oready = 0).
- Counter widths: hits and timeouts cannot exceed cfg_shots. Echoes is SHOT_W+2 bits and saturates at all-ones.
- Asserting rst mid-frame returns to IDLE immediately with reset values; the pending result is lost.
- busy = (state != IDLE).

Decomposition:
- Shared package tdc_pkg holds:
  - FSM state encoding (IDLE, SETUP, START, WAIT, COLLECT, GAP, REPORT)
  - TOF_INVALID constant (all-ones, RANGE_W bits)
  - RANGE_W and INT_W constants
- One natural sub-module, tdc_echo_accum: beat-level min/count accumulator with clear, beat, and shot_end inputs. It is instantiated once, and the FSM stays in tdc_shot_ctrl.

Test Plan:
- Single shot, one echo:
  - Stimulus: cfg_shots=1, cfg_range=0x03FC; one beat odata=0x0123, oint=5, onum=1, olast=1.
  - Required: res_tof=0x0123, res_int=5, hits=1, echoes=1, timeouts=0; tdc_start high exactly 2 cycles.
- Three shots with mixed echoes:
  - Stimulus: shot 1 beats {0x200, 0x7FFF} onum=2; shot 2 empty beat (onum=0); shot 3 beats {0x150, 0x150, 0x300}, oints 3, 9, 1.
  - Required: res_tof=0x150, res_int=3 (tie keeps earliest), hits=2, echoes=4.
- Timeout:
  - Stimulus: cfg_shots=2; no ovalid in shot 1; shot 2 beat 0x010.
  - Required: timeouts=1, hits=1, res_tof=0x010; WAIT lasts exactly TIMEOUT cycles.
- Backpressure on result:
  - Stimulus: hold res_ready=0 for 20 cycles after res_valid.
  - Required: res_* stable throughout; frame_req during REPORT ignored; IDLE one cycle after the handshake.
- Abort:
  - Stimulus: frame_abort during WAIT of shot 2.
  - Required: IDLE next cycle, no res_valid, tdc_oready=0; a new frame_req then runs normally with cleared counts.
- Reset and cfg_shots=0:
  - Stimulus: rst asserted in COLLECT; separately, frame_req with cfg_shots=0.
  - Required: on rst, all outputs at reset values immediately. For cfg_shots=0, res_valid within 2 cycles with zero counts and res_tof=0x7FFF.
